// File: rtl/serial_uart_bridge_pkg.sv
// Shared definitions for the serial UART bridge: 8N1 frame constants,
// default timing/sizing, and TX/RX state encodings.
package serial_uart_bridge_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int FIFO_DEPTH_DEFAULT   = 16;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/serial_uart_bridge_fifo.sv
// Synchronous show-ahead FIFO; full/empty come from a registered occupancy count.
// A push at full is accepted only when a pop happens in the same cycle.
module serial_uart_bridge_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    // Head forced to zero while empty so the read port has a defined reset value.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, do_pop};
        count_d  = count_q + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/serial_uart_bridge.sv
// CPU serial port bridge: TX FIFO feeding an 8N1 serialiser, RX deserialiser
// feeding an RX FIFO, with sticky overrun and framing-error flags.
module serial_uart_bridge
    import serial_uart_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] cpu_wdata_in,
    input  logic                 cpu_wren_in,
    output logic                 cpu_ready_out,
    input  logic                 cpu_rden_in,
    output logic [DATA_BITS-1:0] cpu_rdata_out,
    output logic                 cpu_valid_out,
    input  logic                 uart_rx_in,
    output logic                 uart_tx_out,
    output logic                 tx_busy_out,
    input  logic                 err_clr_in,
    output logic                 rx_overrun_out,
    output logic                 rx_frame_err_out
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

    logic                 tx_full, tx_empty, tx_pop, tx_line;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_full, rx_empty, rx_push, rx_fall, rx_stop_done;
    logic                 rx_overrun_set, rx_frame_set;

    tx_state_t            tx_state_q;
    logic [CNT_W-1:0]     tx_cnt_q;
    logic [2:0]           tx_idx_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_out_q;

    rx_state_t            rx_state_q;
    logic [CNT_W-1:0]     rx_cnt_q;
    logic [2:0]           rx_idx_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q;

    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;

    serial_uart_bridge_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cpu_wren_in && !tx_full),
        .wdata (cpu_wdata_in),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    serial_uart_bridge_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .wdata (rx_shift_q),
        .pop   (cpu_rden_in),
        .rdata (cpu_rdata_out),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign cpu_ready_out    = !tx_full;
    assign cpu_valid_out    = !rx_empty;
    assign uart_tx_out      = tx_out_q;
    assign tx_busy_out      = (tx_state_q != TX_IDLE) || !tx_empty;
    assign rx_overrun_out   = overrun_q;
    assign rx_frame_err_out = frame_err_q;

    always_comb begin
        tx_pop = !tx_empty &&
                 ((tx_state_q == TX_IDLE) || (tx_state_q == TX_STOP && tx_cnt_q == '0));
        case (tx_state_q)
            TX_START: tx_line = START_BIT;
            TX_DATA:  tx_line = tx_shift_q[0];
            default:  tx_line = STOP_BIT;
        endcase
    end

    // Line level is registered from the state, so it trails the FSM by one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_out_q   <= 1'b1;
        end else begin
            tx_out_q <= tx_line;
            if (tx_pop) begin
                tx_state_q <= TX_START;
                tx_cnt_q   <= BIT_LAST;
                tx_shift_q <= tx_head;
            end else begin
                case (tx_state_q)
                    TX_IDLE: ;
                    TX_START:
                        if (tx_cnt_q == '0) begin
                            tx_state_q <= TX_DATA;
                            tx_cnt_q   <= BIT_LAST;
                            tx_idx_q   <= '0;
                        end else begin
                            tx_cnt_q <= tx_cnt_q - CNT_ONE;
                        end
                    TX_DATA:
                        if (tx_cnt_q == '0) begin
                            tx_cnt_q   <= BIT_LAST;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_idx_q   <= tx_idx_q + 3'd1;
                            if (tx_idx_q == LAST_IDX) tx_state_q <= TX_STOP;
                        end else begin
                            tx_cnt_q <= tx_cnt_q - CNT_ONE;
                        end
                    TX_STOP:
                        if (tx_cnt_q == '0) tx_state_q <= TX_IDLE;
                        else                tx_cnt_q   <= tx_cnt_q - CNT_ONE;
                endcase
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_in;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_comb begin
        rx_fall        = rx_prev_q && !rx_sync_q;
        rx_stop_done   = (rx_state_q == RX_STOP) && (rx_cnt_q == '0);
        rx_push        = rx_stop_done && (rx_sync_q == STOP_BIT);
        rx_frame_set   = rx_stop_done && (rx_sync_q != STOP_BIT);
        // A pop in the same cycle frees a slot, so a push at full is not lost then.
        rx_overrun_set = rx_push && rx_full && !cpu_rden_in;
        overrun_d      = rx_overrun_set || (overrun_q && !err_clr_in);
        frame_err_d    = rx_frame_set || (frame_err_q && !err_clr_in);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE:
                    if (rx_fall) begin
                        rx_state_q <= RX_START;
                        rx_cnt_q   <= HALF_LAST;
                    end
                RX_START:
                    if (rx_cnt_q == '0) begin
                        if (rx_sync_q) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_state_q <= RX_DATA;
                            rx_cnt_q   <= BIT_LAST;
                            rx_idx_q   <= '0;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CNT_ONE;
                    end
                RX_DATA:
                    if (rx_cnt_q == '0) begin
                        rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                        rx_cnt_q   <= BIT_LAST;
                        rx_idx_q   <= rx_idx_q + 3'd1;
                        if (rx_idx_q == LAST_IDX) rx_state_q <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q - CNT_ONE;
                    end
                RX_STOP:
                    if (rx_cnt_q == '0) rx_state_q <= RX_IDLE;
                    else                rx_cnt_q   <= rx_cnt_q - CNT_ONE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_serial_uart_bridge.sv
// Scoreboard bench for serial_uart_bridge: stimulus pushes expected bytes into
// queues, a line decoder and a CPU-side reader pop and compare independently.
module tb_serial_uart_bridge;
    localparam int CPB    = 8;
    localparam int DEPTH  = 4;
    localparam int CLK_NS = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] cpu_wdata_in = 8'h00;
    logic       cpu_wren_in = 1'b0;
    logic       cpu_ready_out;
    logic       cpu_rden_in = 1'b0;
    logic [7:0] cpu_rdata_out;
    logic       cpu_valid_out;
    logic       uart_rx_in = 1'b1;
    logic       uart_tx_out;
    logic       tx_busy_out;
    logic       err_clr_in = 1'b0;
    logic       rx_overrun_out;
    logic       rx_frame_err_out;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    time        tx_starts[$];
    logic       rd_en = 1'b0;
    logic       exp_overrun = 1'b0;
    logic       exp_frame = 1'b0;

    serial_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpu_wdata_in     (cpu_wdata_in),
        .cpu_wren_in      (cpu_wren_in),
        .cpu_ready_out    (cpu_ready_out),
        .cpu_rden_in      (cpu_rden_in),
        .cpu_rdata_out    (cpu_rdata_out),
        .cpu_valid_out    (cpu_valid_out),
        .uart_rx_in       (uart_rx_in),
        .uart_tx_out      (uart_tx_out),
        .tx_busy_out      (tx_busy_out),
        .err_clr_in       (err_clr_in),
        .rx_overrun_out   (rx_overrun_out),
        .rx_frame_err_out (rx_frame_err_out)
    );

    always #(CLK_NS/2) clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s at %0t", name, what, $time);
    endtask

    // Expected TX line k cycles after the edge that accepted byte b into an idle transmitter.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int j;
        if (k < 2) return 1'b1;
        j = (k - 2) / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    task automatic rx_model(input logic [7:0] b, input logic stop_ok);
        if (!stop_ok)                 exp_frame = 1'b1;
        else if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
        else                          exp_overrun = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx_in = fr[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx_in = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        cpu_wdata_in = b;
        cpu_wren_in  = 1'b1;
        @(negedge clock);
        cpu_wren_in  = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr_in = 1'b1;
        @(negedge clock);
        err_clr_in = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_tx_drain(input string name);
        int n;
        n = 0;
        while ((tx_exp.size() != 0 || tx_busy_out) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) fail_now(name, "timeout waiting for TX to drain");
        repeat (8) @(negedge clock);
    endtask

    task automatic wait_rx_drain(input string name);
        int n;
        n = 0;
        while (rx_exp.size() != 0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) fail_now(name, "timeout waiting for RX reads");
    endtask

    // Decodes uart_tx_out at bit centres and scores each byte against tx_exp.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       ab, st, sp;
        time        t0;
        forever begin
            @(negedge clock);
            if (!reset && uart_tx_out === 1'b0) begin
                t0 = $time;
                ab = 1'b0;
                b  = 8'h00;
                for (int c = 0; c < CPB/2; c++) begin
                    @(negedge clock);
                    if (reset) ab = 1'b1;
                end
                st = uart_tx_out;
                for (int i = 0; i < 8; i++) begin
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clock);
                        if (reset) ab = 1'b1;
                    end
                    b[i] = uart_tx_out;
                end
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clock);
                    if (reset) ab = 1'b1;
                end
                sp = uart_tx_out;
                if (!ab) begin
                    tx_starts.push_back(t0);
                    check("tx_start_bit", {31'd0, st}, 32'd0);
                    check("tx_stop_bit", {31'd0, sp}, 32'd1);
                    if (tx_exp.size() == 0) fail_now("tx_unexpected", $sformatf("byte 0x%0h with none expected", b));
                    else                    check("tx_byte", {24'd0, b}, {24'd0, tx_exp.pop_front()});
                end
            end
        end
    end

    // CPU-side reader: pops whenever data is presented and reads are enabled.
    initial begin : rx_reader
        forever begin
            @(negedge clock);
            cpu_rden_in = 1'b0;
            if (rd_en && !reset && cpu_valid_out) begin
                if (rx_exp.size() == 0) fail_now("rx_unexpected", $sformatf("byte 0x%0h with none expected", cpu_rdata_out));
                else                    check("rx_byte", {24'd0, cpu_rdata_out}, {24'd0, rx_exp.pop_front()});
                cpu_rden_in = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #(60000 * CLK_NS);
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] b;
        int         cnt_m, n;
        logic       idle_m, acc, pop_m;

        repeat (3) @(negedge clock);
        check("rst_tx_out", {31'd0, uart_tx_out}, 32'd1);
        check("rst_ready", {31'd0, cpu_ready_out}, 32'd1);
        check("rst_valid", {31'd0, cpu_valid_out}, 32'd0);
        check("rst_rdata", {24'd0, cpu_rdata_out}, 32'd0);
        check("rst_busy", {31'd0, tx_busy_out}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("idle_tx_out", {31'd0, uart_tx_out}, 32'd1);
        check("idle_busy", {31'd0, tx_busy_out}, 32'd0);
        check("idle_overrun", {31'd0, rx_overrun_out}, 32'd0);
        check("idle_frame_err", {31'd0, rx_frame_err_out}, 32'd0);

        // Single byte 0xA5: cycle-exact line waveform and busy window.
        tx_exp.push_back(8'hA5);
        cpu_wdata_in = 8'hA5;
        cpu_wren_in  = 1'b1;
        @(negedge clock);
        cpu_wren_in  = 1'b0;
        for (int k = 0; k < 86; k++) begin
            check($sformatf("a5_line_k%0d", k), {31'd0, uart_tx_out}, {31'd0, exp_line(8'hA5, k)});
            check($sformatf("a5_busy_k%0d", k), {31'd0, tx_busy_out}, (k <= 80) ? 32'd1 : 32'd0);
            @(negedge clock);
        end
        wait_tx_drain("a5_drain");

        // Burst of six writes into a depth-4 FIFO with an idle transmitter.
        tx_starts.delete();
        cnt_m  = 0;
        idle_m = 1'b1;
        for (int i = 0; i < 6; i++) begin
            acc = (cnt_m < DEPTH);
            check($sformatf("burst_ready_%0d", i), {31'd0, cpu_ready_out}, {31'd0, acc});
            cpu_wdata_in = 8'(i + 1);
            cpu_wren_in  = 1'b1;
            if (acc) tx_exp.push_back(8'(i + 1));
            pop_m = idle_m && (cnt_m > 0);
            cnt_m = cnt_m + int'(acc) - int'(pop_m);
            if (pop_m) idle_m = 1'b0;
            @(negedge clock);
        end
        cpu_wren_in = 1'b0;
        check("burst_ready_after", {31'd0, cpu_ready_out}, (cnt_m < DEPTH) ? 32'd1 : 32'd0);
        wait_tx_drain("burst_drain");
        check("burst_frames", tx_starts.size(), 32'd5);
        for (int i = 1; i < tx_starts.size(); i++)
            check($sformatf("burst_gap_%0d", i), 32'((tx_starts[i] - tx_starts[i-1]) / CLK_NS), 32'(10 * CPB));

        // RX 0x3C held until software reads it.
        rd_en = 1'b0;
        rx_model(8'h3C, 1'b1);
        send_rx(8'h3C, 1'b1);
        n = 0;
        while (!cpu_valid_out && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rx3c_valid", {31'd0, cpu_valid_out}, 32'd1);
        check("rx3c_rdata", {24'd0, cpu_rdata_out}, 32'h3C);
        rd_en = 1'b1;
        wait_rx_drain("rx3c_read");
        @(negedge clock);
        check("rx3c_valid_after_read", {31'd0, cpu_valid_out}, 32'd0);

        // Five frames without reading: the fifth overflows.
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            rx_model(b, 1'b1);
            send_rx(b, 1'b1);
        end
        repeat (4) @(negedge clock);
        check("ovr_flag", {31'd0, rx_overrun_out}, {31'd0, exp_overrun});
        check("ovr_valid", {31'd0, cpu_valid_out}, 32'd1);
        check("ovr_no_frame_err", {31'd0, rx_frame_err_out}, 32'd0);
        pulse_err_clr();
        exp_overrun = 1'b0;
        check("ovr_cleared", {31'd0, rx_overrun_out}, 32'd0);
        rd_en = 1'b1;
        wait_rx_drain("ovr_read");
        repeat (2) @(negedge clock);
        check("ovr_empty", {31'd0, cpu_valid_out}, 32'd0);

        // Bad stop bit, then a short glitch that must be rejected.
        rx_model(8'h5A, 1'b0);
        send_rx(8'h5A, 1'b0);
        repeat (4) @(negedge clock);
        check("ferr_flag", {31'd0, rx_frame_err_out}, {31'd0, exp_frame});
        check("ferr_no_push", {31'd0, cpu_valid_out}, 32'd0);
        pulse_err_clr();
        exp_frame = 1'b0;
        check("ferr_cleared", {31'd0, rx_frame_err_out}, 32'd0);
        uart_rx_in = 1'b0;
        repeat (3) @(negedge clock);
        uart_rx_in = 1'b1;
        repeat (30) @(negedge clock);
        check("glitch_no_push", {31'd0, cpu_valid_out}, 32'd0);
        check("glitch_no_ferr", {31'd0, rx_frame_err_out}, 32'd0);
        check("glitch_no_ovr", {31'd0, rx_overrun_out}, 32'd0);

        // Random TX bytes, each written once the FIFO has room.
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!cpu_ready_out && n < 500) begin
                @(negedge clock);
                n++;
            end
            if (n >= 500) fail_now("rand_tx_ready", "timeout waiting for ready");
            b = 8'($urandom);
            tx_exp.push_back(b);
            write_byte(b);
            repeat ($urandom_range(0, 120)) @(negedge clock);
        end
        wait_tx_drain("rand_tx_drain");

        // Random RX frames with random gaps, read as they arrive.
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            rx_model(b, 1'b1);
            send_rx(b, 1'b1);
            repeat ($urandom_range(0, 15)) @(negedge clock);
        end
        wait_rx_drain("rand_rx_read");
        check("rand_rx_no_ovr", {31'd0, rx_overrun_out}, 32'd0);
        check("rand_rx_no_ferr", {31'd0, rx_frame_err_out}, 32'd0);

        // Reset in the middle of a TX frame with both FIFOs holding data.
        rd_en = 1'b0;
        rx_model(8'h81, 1'b1);
        send_rx(8'h81, 1'b1);
        repeat (4) @(negedge clock);
        check("mid_rx_loaded", {31'd0, cpu_valid_out}, 32'd1);
        tx_exp.push_back(8'h00);
        write_byte(8'h00);
        tx_exp.push_back(8'h7E);
        write_byte(8'h7E);
        repeat (20) @(negedge clock);
        check("mid_tx_low", {31'd0, uart_tx_out}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_tx_out", {31'd0, uart_tx_out}, 32'd1);
        check("mid_rst_ready", {31'd0, cpu_ready_out}, 32'd1);
        check("mid_rst_valid", {31'd0, cpu_valid_out}, 32'd0);
        check("mid_rst_rdata", {24'd0, cpu_rdata_out}, 32'd0);
        check("mid_rst_busy", {31'd0, tx_busy_out}, 32'd0);
        tx_exp.delete();
        rx_exp.delete();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        check("post_rst_tx_idle", {31'd0, uart_tx_out}, 32'd1);
        check("post_rst_busy", {31'd0, tx_busy_out}, 32'd0);
        tx_exp.push_back(8'h96);
        write_byte(8'h96);
        wait_tx_drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
